// File: rtl/hack_mul_seq.sv
// rtl/hack_mul_seq.sv - shift-and-add multiply sequencer driving an external Hack ALU
// Purpose: computes the low DW bits of a*b, one ALU operation per cycle (ADD then DBL).
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   start_i, a_i, b_i       request pulse and operands (sampled in IDLE only)
//   busy_o, done_o          high in ADD/DBL; one-cycle completion pulse
//   product_o               accumulator, valid with done_o and afterwards in IDLE
//   alu_x_o, alu_y_o        ALU operands
//   alu_zx_o..alu_no_o      ALU control bits
//   alu_out_i               ALU result, combinational in the same cycle
// Optional macro HACK_MUL_EARLY_EXIT_EN: leave the loop as soon as the multiplier is zero.

`ifndef DataWidth
`define DataWidth 16
`endif

module hack_mul_seq #(
   parameter int DW = `DataWidth
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          start_i,
   input  logic [DW-1:0] a_i,
   input  logic [DW-1:0] b_i,
   output logic          busy_o,
   output logic          done_o,
   output logic [DW-1:0] product_o,
   output logic [DW-1:0] alu_x_o,
   output logic [DW-1:0] alu_y_o,
   output logic          alu_zx_o,
   output logic          alu_nx_o,
   output logic          alu_zy_o,
   output logic          alu_ny_o,
   output logic          alu_f_o,
   output logic          alu_no_o,
   input  logic [DW-1:0] alu_out_i
);

   localparam int CNT_W = $clog2(DW + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DW);

   typedef enum logic [1:0] {S_IDLE, S_ADD, S_DBL, S_DONE} state_t;

   state_t          state;
   logic [DW-1:0]   acc;
   logic [DW-1:0]   mcand;
   logic [DW-1:0]   mplier;
   logic [CNT_W-1:0] cnt;
   logic            busy_q;
   logic            done_q;
   logic            add_exit;

   // Exit is evaluated at the top of ADD, so the exit ADD cycle performs no ALU operation.
`ifdef HACK_MUL_EARLY_EXIT_EN
   assign add_exit = (cnt == LAST_CNT) || (mplier == '0);
`else
   assign add_exit = (cnt == LAST_CNT);
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state  <= S_IDLE;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         cnt    <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start_i) begin
                  acc    <= '0;
                  mcand  <= a_i;
                  mplier <= b_i;
                  cnt    <= '0;
                  busy_q <= 1'b1;
                  state  <= S_ADD;
               end
            end
            S_ADD: begin
               if (add_exit) begin
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  state  <= S_DONE;
               end else begin
                  acc   <= alu_out_i;
                  state <= S_DBL;
               end
            end
            S_DBL: begin
               mcand  <= alu_out_i;
               mplier <= mplier >> 1;
               cnt    <= cnt + 1'b1;
               state  <= S_ADD;
            end
            S_DONE: begin
               // start_i is deliberately not looked at here.
               done_q <= 1'b0;
               state  <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // ALU drive is decoded from registered state so alu_out_i settles within the cycle.
   always_comb begin
      alu_x_o  = '0;
      alu_y_o  = '0;
      alu_zx_o = 1'b0;
      alu_nx_o = 1'b0;
      alu_zy_o = 1'b0;
      alu_ny_o = 1'b0;
      alu_f_o  = 1'b0;
      alu_no_o = 1'b0;
      case (state)
         S_ADD: begin
            if (!add_exit) begin
               // zy masks mcand when the current multiplier bit is 0: acc + 0.
               alu_x_o  = acc;
               alu_y_o  = mcand;
               alu_zy_o = ~mplier[0];
               alu_f_o  = 1'b1;
            end
         end
         S_DBL: begin
            alu_x_o = mcand;
            alu_y_o = mcand;
            alu_f_o = 1'b1;
         end
         default: ;
      endcase
   end

   assign busy_o    = busy_q;
   assign done_o    = done_q;
   assign product_o = acc;

endmodule

// File: tb/tb_hack_mul_seq.sv
// tb/tb_hack_mul_seq.sv - scoreboard bench for hack_mul_seq with a behavioural Hack ALU
module tb_hack_mul_seq;

   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst_i;
   logic          start_i;
   logic [DW-1:0] a_i, b_i;
   logic          busy_o, done_o;
   logic [DW-1:0] product_o;
   logic [DW-1:0] alu_x_o, alu_y_o, alu_out;
   logic          alu_zx_o, alu_nx_o, alu_zy_o, alu_ny_o, alu_f_o, alu_no_o;

   hack_mul_seq #(.DW(DW)) dut (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .a_i(a_i), .b_i(b_i),
      .busy_o(busy_o), .done_o(done_o), .product_o(product_o),
      .alu_x_o(alu_x_o), .alu_y_o(alu_y_o),
      .alu_zx_o(alu_zx_o), .alu_nx_o(alu_nx_o), .alu_zy_o(alu_zy_o),
      .alu_ny_o(alu_ny_o), .alu_f_o(alu_f_o), .alu_no_o(alu_no_o),
      .alu_out_i(alu_out)
   );

   always #5 clk = ~clk;

   // Hack ALU
   logic [DW-1:0] xs, ys, r;
   always_comb begin
      xs = alu_zx_o ? '0 : alu_x_o;
      if (alu_nx_o) xs = ~xs;
      ys = alu_zy_o ? '0 : alu_y_o;
      if (alu_ny_o) ys = ~ys;
      r = alu_f_o ? (xs + ys) : (xs & ys);
      alu_out = alu_no_o ? ~r : r;
   end

   int edge_n = 0;
   always @(posedge clk) edge_n <= edge_n + 1;

   typedef struct packed {
      logic [DW-1:0] prod;
      int            n;
      int            lat;
   } exp_t;

   exp_t sb[$];
   int checks = 0;
   int errors = 0;
   int last_n = 0;

   logic [15:0] ta [8] = '{16'd3, 16'hFFFF, 16'hFFFD, 16'h1234, 16'd1, 16'h8001, 16'h00FF, 16'hABCD};
   logic [15:0] tb_ [8] = '{16'd5, 16'hFFFF, 16'd7,    16'd0,    16'd1, 16'h8000, 16'h0101, 16'h0003};

   function automatic int exp_lat(input logic [DW-1:0] b);
`ifdef HACK_MUL_EARLY_EXIT_EN
      int l;
      l = 0;
      for (int i = 0; i < DW; i++) if (b[i]) l = i + 1;
      return 2 * l + 2;
`else
      return 34;
`endif
   endfunction

   // Drives a start in IDLE and leaves the bench at the negedge of cycle T+1.
   task automatic start_op(input logic [DW-1:0] a, input logic [DW-1:0] b);
      exp_t e;
      logic [DW-1:0] p;
      p = a * b;
      a_i = a; b_i = b; start_i = 1'b1;
      e.prod = p; e.n = edge_n; e.lat = exp_lat(b);
      last_n = edge_n;
      sb.push_back(e);
      @(negedge clk);
      start_i = 1'b0;
      checks++;
      if (busy_o !== 1'b1) begin
         errors++; $display("FAIL busy_after_start got %b want 1", busy_o);
      end
   endtask

   // Stops at the negedge of the DONE cycle after popping and checking the scoreboard.
   task automatic wait_done();
      exp_t e;
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (done_o) begin seen = 1'b1; break; end
         @(negedge clk);
      end
      checks++;
      if (!seen) begin
         errors++; $display("FAIL done_timeout got no done want done within 40 cycles");
         if (sb.size() > 0) void'(sb.pop_front());
      end else if (sb.size() == 0) begin
         errors++; $display("FAIL unexpected_done got done want none");
      end else begin
         e = sb.pop_front();
         if (product_o !== e.prod) begin
            errors++; $display("FAIL product got %h want %h", product_o, e.prod);
         end
         checks++;
         if (edge_n - e.n !== e.lat) begin
            errors++; $display("FAIL latency got %0d want %0d", edge_n - e.n, e.lat);
         end
         checks++;
         if (busy_o !== 1'b0) begin
            errors++; $display("FAIL busy_at_done got %b want 0", busy_o);
         end
      end
   endtask

   task automatic do_mul(input logic [DW-1:0] a, input logic [DW-1:0] b);
      logic [DW-1:0] p;
      p = a * b;
      start_op(a, b);
      wait_done();
      @(negedge clk);
      checks++;
      if (done_o !== 1'b0 || busy_o !== 1'b0 || product_o !== p) begin
         errors++;
         $display("FAIL idle_hold got done=%b busy=%b prod=%h want 0 0 %h", done_o, busy_o, product_o, p);
      end
   endtask

   task automatic wait_k(input int k);
      for (int i = 0; i < 60 && (edge_n - last_n) < k; i++) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_i = 1'b1; start_i = 1'b0; a_i = '0; b_i = '0;
      @(negedge clk); @(negedge clk);
      checks++;
      if (busy_o !== 1'b0 || done_o !== 1'b0 || product_o !== '0) begin
         errors++; $display("FAIL reset_outs got busy=%b done=%b prod=%h want 0 0 0", busy_o, done_o, product_o);
      end
      checks++;
      if ({alu_x_o, alu_y_o, alu_zx_o, alu_nx_o, alu_zy_o, alu_ny_o, alu_f_o, alu_no_o} !== '0) begin
         errors++; $display("FAIL reset_alu got x=%h y=%h f=%b zy=%b want all 0", alu_x_o, alu_y_o, alu_f_o, alu_zy_o);
      end
      rst_i = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_alu_drive();
      start_op(16'd7, 16'd2);
      checks++;
      if (alu_zy_o !== 1'b1 || alu_x_o !== 16'd0 || alu_y_o !== 16'd7 || alu_f_o !== 1'b1 || product_o !== 16'd0) begin
         errors++; $display("FAIL alu_t1 got zy=%b x=%h y=%h f=%b acc=%h want 1 0 7 1 0", alu_zy_o, alu_x_o, alu_y_o, alu_f_o, product_o);
      end
      @(negedge clk);
      checks++;
      if (alu_x_o !== 16'd7 || alu_y_o !== 16'd7 || alu_zy_o !== 1'b0 || alu_out !== 16'd14) begin
         errors++; $display("FAIL alu_t2 got x=%h y=%h zy=%b out=%h want 7 7 0 e", alu_x_o, alu_y_o, alu_zy_o, alu_out);
      end
      @(negedge clk);
      checks++;
      if (alu_zy_o !== 1'b0 || alu_x_o !== 16'd0 || alu_y_o !== 16'd14 || alu_out !== 16'd14) begin
         errors++; $display("FAIL alu_t3 got zy=%b x=%h y=%h out=%h want 0 0 e e", alu_zy_o, alu_x_o, alu_y_o, alu_out);
      end
      wait_done();
      @(negedge clk);
   endtask

   task automatic test_products();
      for (int i = 0; i < 8; i++) do_mul(ta[i], tb_[i]);
      for (int i = 0; i < 4; i++) do_mul(DW'($urandom), DW'($urandom));
   endtask

   task automatic test_ignored_start();
      start_op(16'd3, 16'd5);
      wait_k(5);
      a_i = 16'd100; b_i = 16'd100; start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      wait_done();
      a_i = 16'd9; b_i = 16'd9; start_i = 1'b1;
      @(negedge clk);
      checks++;
      if (busy_o !== 1'b0 || product_o !== 16'd15) begin
         errors++; $display("FAIL start_in_done got busy=%b prod=%h want 0 000f", busy_o, product_o);
      end
      do_mul(16'd9, 16'd9);
   endtask

   task automatic test_reset_mid();
      int dones;
      start_op(16'h1234, 16'h0FFF);
      wait_k(10);
      rst_i = 1'b1;
      @(negedge clk);
      rst_i = 1'b0;
      sb.delete();
      checks++;
      if (busy_o !== 1'b0 || done_o !== 1'b0 || product_o !== '0 || alu_f_o !== 1'b0 || alu_x_o !== '0) begin
         errors++; $display("FAIL reset_mid got busy=%b done=%b prod=%h f=%b want 0 0 0 0", busy_o, done_o, product_o, alu_f_o);
      end
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done_o) dones++;
      end
      checks++;
      if (dones !== 0) begin
         errors++; $display("FAIL reset_no_done got %0d pulses want 0", dones);
      end
      rst_i = 1'b1; start_i = 1'b1; a_i = 16'd5; b_i = 16'd5;
      @(negedge clk);
      rst_i = 1'b0; start_i = 1'b0;
      @(negedge clk);
      checks++;
      if (busy_o !== 1'b0) begin
         errors++; $display("FAIL reset_priority got busy=%b want 0", busy_o);
      end
      do_mul(16'hFFFD, 16'd7);
   endtask

   initial begin
      rst_i = 1'b1; start_i = 1'b0; a_i = '0; b_i = '0;
      test_reset();
      test_alu_drive();
      test_products();
      test_ignored_start();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
